arbitro_barramento: RTL
=======================

# arbitro_barramento

Central arbiter and sequencer for the shared 11-bit snoop bus connecting four MSI `processador` caches. It grants the bus round-robin to one requesting processor and broadcasts that processor's command word. It runs the snoop window for read misses and returns data from a peer cache, or from a 2-entry backing memory when no peer responds. It also absorbs write-backs into that memory.

## Interface
- `SNOOP_WIN`, default 2: cycles the arbiter waits for a peer `return` after broadcasting a readMiss (≥1).
- `MEM_LAT`, default 2: extra cycles before the memory response is driven (≥0).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req`  in  4  per-processor bus request; bit i = processor i.
- `bar_req`  in  44  processor bus words; bits [11i+10:11i] = processor i, in bus format: [10] shared flag, [9:8] proc id, [7] wb, [6] wb tag, [5:4] msg (00 none, 01 readMiss, 10 invalidate, 11 return), [3] tag, [2:0] data.
- `gnt`  out  4  one-hot grant, high for the whole owned transaction.
- `barin`  out  11  broadcast bus word seen by all processors.
- `owner`  out  2  id of the current or last owner.
- `busy`  out  1  high while any transaction is in progress (state ≠ IDLE).
- `txn_done`  out  1  one-cycle pulse in the final cycle of each transaction.

## Operation
- Internal memory `mem[0:1]`, 3 bits each, indexed by tag.
- FSM states: IDLE, BROADCAST, SNOOP, MEM_WAIT, RESPOND.
- **Reset values:**
  - FSM to IDLE.
  - `gnt`=0, `barin`=0, `owner`=0, `busy`=0, `txn_done`=0.
  - `last_owner`=3, so processor 0 has first priority.
  - `mem` all 0.
- **IDLE:**
  - If `req`≠0, the winner is the first set bit scanning `last_owner+1`, `+2`, … modulo 4.
  - Latch the winner's `bar_req` slice into `cmd` and force `cmd[9:8]`=winner id.
  - Set `owner` and `gnt`, then go to BROADCAST.
  - If `req`=0, `barin`=0.
- **BROADCAST** (1 cycle):
  - `barin`=`cmd`.
  - If `cmd[7]`, write `mem[cmd[6]]`←`cmd[2:0]`.
  - msg 01: load the snoop counter with `SNOOP_WIN` and go to SNOOP.
  - msg 10, 00 or 11: end the transaction by going to IDLE, with `txn_done`=1 in this cycle.
- **SNOOP:**
  - `barin`=0.
  - A hit is any processor j ≠ `owner` with `bar_req` msg=11 and [9:8]=`owner`. The lowest j wins simultaneous hits.
  - On a hit:
    - Capture `resp` = that word with [10]=1 and [9:8]=`owner`.
    - If the word has [7]=1, write `mem[word[6]]`←`word[2:0]`.
    - Go to RESPOND.
  - Without a hit, decrement the counter; at 0, load `MEM_LAT` and go to MEM_WAIT.
- **MEM_WAIT:**
  - `barin`=0.
  - Count down; at 0 (immediately if `MEM_LAT`=0), form `resp` = {0, `owner`, 0, 0, 11, `cmd[3]`, `mem[cmd[3]]`} and go to RESPOND.
  - A late peer `return` is ignored.
- **RESPOND** (1 cycle): `barin`=`resp`, `txn_done`=1, `last_owner`←`owner`, then go to IDLE.
- `gnt` is cleared on the cycle the FSM enters IDLE.
- `req` changes during a transaction are ignored.
- Non-owner command words (msg 01/10) arriving during a transaction are ignored; those requesters stay pending.
- The owner's own msg=11 word never counts as a snoop hit.
- `rst` mid-transaction aborts it. The next edge yields reset values and `mem` is cleared; no `txn_done` is pulsed.

## Timing
- Grant latency: `req` sampled in IDLE at edge N gives `gnt`/`busy` high and `barin`=`cmd` from edge N+1.
- Invalidate or write-back-only transaction: 1 owned cycle.
- ReadMiss, peer hit on the k-th snoop cycle: 1 + k + 1 owned cycles.
- ReadMiss served by memory: 1 + `SNOOP_WIN` + `MEM_LAT` + 1 owned cycles.
- At least one IDLE cycle separates transactions; with `req` held constant, grants rotate strictly 0→1→2→3→0.
- A memory write in BROADCAST is visible to a memory response in the same transaction (its tag read occurs later).

## Test plan
- Reset, then `req`=0000 for 5 cycles -> `gnt`=0, `barin`=0, `busy`=0 throughout; first grant after `req`=1111 goes to processor 0.
- `req`=1111 held, each word an invalidate -> grants 0,1,2,3,0 with one IDLE cycle between; `txn_done` is one pulse per grant, 2-cycle period.
- P1 readMiss tag 1 (defaults); P2 drives return {0,01,0,0,11,1,101} on the 1st snoop cycle -> `barin`=11'b1_01_0_0_11_1_101 in the next cycle; `mem` unchanged.
- P0 write-back (wb=1, wb tag 0, data 110, msg 00), then P3 readMiss tag 0 with no peer response -> after 2 snoop + 2 wait cycles, `barin`={0,11,0,0,11,0,110}.
- P1 and P3 both return in the same snoop cycle for owner P0 -> P1's data is forwarded; a P3 word with wb=1 is not written to `mem`.
- `rst` asserted during MEM_WAIT -> the next cycle shows IDLE, `gnt`=0, `barin`=0, no `txn_done`; a subsequent memory read returns 000.

Source files
------------

// File: rtl/arbitro_barramento.sv
// arbitro_barramento
//   Central arbiter and sequencer for the 11-bit snoop bus that is shared by
//   four MSI caches. It grants the bus round-robin, broadcasts the owner's
//   command word, and runs the snoop window for read misses. The response
//   comes from a peer cache, or from a 2-entry backing memory when no peer
//   answers. Write-backs carried on the bus are absorbed into that memory.
//
//   Bus word layout: [10] shared, [9:8] proc id, [7] wb, [6] wb tag,
//                    [5:4] msg (00 none, 01 readMiss, 10 invalidate, 11 return),
//                    [3] tag, [2:0] data
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   [3:0]  per-processor bus request
//   bar_req   in   [43:0] processor bus words, slice i = bits [11i+10:11i]
//   gnt       out  [3:0]  one-hot grant for the whole owned transaction
//   barin     out  [10:0] broadcast bus word
//   owner     out  [1:0]  current or last owner id
//   busy      out  transaction in progress
//   txn_done  out  one-cycle pulse in the final cycle of each transaction
module arbitro_barramento #(
  parameter int SNOOP_WIN = 2,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [43:0] bar_req,
  output logic [3:0]  gnt,
  output logic [10:0] barin,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        txn_done
);

  localparam int CNT_MAX = (SNOOP_WIN > MEM_LAT) ? SNOOP_WIN : MEM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SNOOP_LOAD = CNT_W'(SNOOP_WIN);
  localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] MSG_RDMISS = 2'b01;
  localparam logic [1:0] MSG_RET    = 2'b11;

  typedef enum logic [2:0] {IDLE, BROADCAST, SNOOP, MEM_WAIT, RESPOND} state_t;

  state_t           state_q, state_d;
  logic [10:0]      cmd_q, cmd_d;
  logic [10:0]      resp_q, resp_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mem_q [2];

  logic             mem_we;
  logic             mem_wa;
  logic [2:0]       mem_wd;

  logic [3:0][10:0] word;
  logic [3:0]       hit_vec;
  logic             win_valid;
  logic [1:0]       win_id;
  logic [1:0]       scan_id;
  logic             hit_valid;
  logic [1:0]       hit_id;
  logic [10:0]      mem_resp;

  // Per-processor slices and snoop-hit qualification. The owner's own
  // return word is excluded so it can never satisfy its own miss.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_proc
      assign word[gi]    = bar_req[11*gi +: 11];
      assign hit_vec[gi] = (2'(gi) != owner_q) &&
                           (word[gi][5:4] == MSG_RET) &&
                           (word[gi][9:8] == owner_q);
    end
  endgenerate

  // Round-robin: first requester after the last owner, wrapping modulo 4.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 2'd0;
    scan_id   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_id = last_owner_q + 2'(k);
      if (!win_valid && req[scan_id]) begin
        win_valid = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // Fixed priority among simultaneous snoop hits: scanning downwards lets
  // the lowest index overwrite the others.
  always_comb begin
    hit_valid = 1'b0;
    hit_id    = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (hit_vec[j]) begin
        hit_valid = 1'b1;
        hit_id    = 2'(j);
      end
    end
  end

  assign mem_resp = {1'b0, owner_q, 1'b0, 1'b0, MSG_RET, cmd_q[3], mem_q[cmd_q[3]]};

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    resp_d       = resp_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_we       = 1'b0;
    mem_wa       = 1'b0;
    mem_wd       = 3'd0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          cmd_d   = {word[win_id][10], win_id, word[win_id][7:0]};
          owner_d = win_id;
          state_d = BROADCAST;
        end
      end
      BROADCAST: begin
        if (cmd_q[7]) begin
          mem_we = 1'b1;
          mem_wa = cmd_q[6];
          mem_wd = cmd_q[2:0];
        end
        if (cmd_q[5:4] == MSG_RDMISS) begin
          cnt_d   = SNOOP_LOAD;
          state_d = SNOOP;
        end else begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      SNOOP: begin
        if (hit_valid) begin
          resp_d = {1'b1, owner_q, word[hit_id][7:0]};
          if (word[hit_id][7]) begin
            mem_we = 1'b1;
            mem_wa = word[hit_id][6];
            mem_wd = word[hit_id][2:0];
          end
          state_d = RESPOND;
        end else if (cnt_q == CNT_ONE) begin
          // With zero memory latency the response is formed straight away.
          if (MEM_LAT == 0) begin
            resp_d  = mem_resp;
            state_d = RESPOND;
          end else begin
            cnt_d   = MEM_LOAD;
            state_d = MEM_WAIT;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          resp_d  = mem_resp;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESPOND: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= 11'd0;
      resp_q       <= 11'd0;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      cnt_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= 3'd0;
      end
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      resp_q       <= resp_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      if (mem_we) begin
        mem_q[mem_wa] <= mem_wd;
      end
    end
  end

  // Outputs are decoded from the registered state, so they change only on
  // clock edges.
  assign busy     = (state_q != IDLE);
  assign gnt      = busy ? (4'b0001 << owner_q) : 4'b0000;
  assign owner    = owner_q;
  assign txn_done = ((state_q == BROADCAST) && (cmd_q[5:4] != MSG_RDMISS)) ||
                    (state_q == RESPOND);

  always_comb begin
    barin = 11'd0;
    case (state_q)
      BROADCAST: barin = cmd_q;
      RESPOND:   barin = resp_q;
      default:   barin = 11'd0;
    endcase
  end

endmodule
